sprite_list_sequencer: RTL and testbench

Per-scanline scheduler for the sprite list held in the mainboard sprite RAM. On each line-start pulse it walks the sprite entries in order, fetches the four bytes of each entry, and pulses the matching register-latch strobe as each byte arrives. It checks every sprite's vertical position against the line being built. For each sprite that hits, it hands one draw request to the downstream line-buffer writer over a req/ack handshake. It replaces fixed PROM sequencing with a programmable, stall-capable controller ahead of the sprite register latches and 32K staging RAM.

---
 rtl/sprite_list_sequencer_if.sv | 34 +++
 rtl/sprite_list_sequencer.sv | 120 ++++++++++++
 tb/tb_sprite_list_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_list_sequencer_if.sv
// Bus bundle between the sprite list sequencer, the sprite RAM, the line-start source
// and the line-buffer writer.
interface sprite_list_sequencer_if;
    logic        line_start;
    logic [7:0]  target_line;
    logic [7:0]  ram_q;
    logic        draw_ack;
    logic [10:0] ram_addr;
    logic        lat_indx;
    logic        lat_xdat;
    logic        lat_vpos;
    logic        lat_hpos;
    logic        draw_req;
    logic [3:0]  draw_vpix;
    logic        busy;
    logic        line_done;
    logic        overrun;
    logic [2:0]  dbg_state;

    // draw_req/draw_ack: draw_req rises with draw_vpix valid and both stay stable until
    // the first cycle where draw_req && draw_ack; draw_req is low on the following cycle.
    // A line_start that aborts a scan withdraws draw_req without an ack.
    modport master (
        input  line_start, target_line, ram_q, draw_ack,
        output ram_addr, lat_indx, lat_xdat, lat_vpos, lat_hpos,
        output draw_req, draw_vpix, busy, line_done, overrun, dbg_state
    );

    modport slave (
        output line_start, target_line, ram_q, draw_ack,
        input  ram_addr, lat_indx, lat_xdat, lat_vpos, lat_hpos,
        input  draw_req, draw_vpix, busy, line_done, overrun, dbg_state
    );
endinterface

// File: rtl/sprite_list_sequencer.sv
// Per-scanline sprite list walker: fetches each 4-byte entry, strobes the register
// latches, tests VPOS against the target line and issues draw requests for hits.
module sprite_list_sequencer #(
    parameter int NUM_SPRITES = 128,
    parameter int SPR_HEIGHT  = 16
) (
    input logic                     pixel_clk,
    input logic                     SPR_ROM_ADDR_RST,
    sprite_list_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EVAL  = 3'd2,
        S_DRAW  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [8:0] LAST_ENTRY = 9'(NUM_SPRITES - 1);
    localparam logic [7:0] HEIGHT     = 8'(SPR_HEIGHT);

    state_t      state_q, state_d;
    logic [8:0]  entry_q, entry_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  target_q, target_d;
    logic [7:0]  vpos_q, vpos_d;
    logic [3:0]  vpix_q, vpix_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  diff;
    logic        advance;
    logic        scanning;

    assign scanning = (state_q == S_FETCH) || (state_q == S_EVAL) || (state_q == S_DRAW);

    always_comb begin
        state_d   = state_q;
        entry_d   = entry_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        vpos_d    = vpos_q;
        vpix_d    = vpix_q;
        overrun_d = 1'b0;
        advance   = 1'b0;
        diff      = target_q - vpos_q;

        // A new line always wins, even mid-scan; the old scan is simply dropped.
        if (bus.line_start) begin
            state_d   = S_FETCH;
            target_d  = bus.target_line;
            entry_d   = 9'd0;
            cnt_d     = 3'd0;
            overrun_d = scanning;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (cnt_q == 3'd3) vpos_d = bus.ram_q;
                    if (cnt_q == 3'd4) begin
                        cnt_d   = 3'd0;
                        state_d = S_EVAL;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                S_EVAL: begin
                    if (diff < HEIGHT) begin
                        vpix_d  = diff[3:0];
                        state_d = S_DRAW;
                    end else begin
                        advance = 1'b1;
                    end
                end
                S_DRAW:  advance = bus.draw_ack;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase

            if (advance) begin
                if (entry_q == LAST_ENTRY) begin
                    state_d = S_DONE;
                end else begin
                    entry_d = entry_q + 9'd1;
                    state_d = S_FETCH;
                end
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge SPR_ROM_ADDR_RST) begin
        if (SPR_ROM_ADDR_RST) begin
            state_q   <= S_IDLE;
            entry_q   <= 9'd0;
            cnt_q     <= 3'd0;
            target_q  <= 8'd0;
            vpos_q    <= 8'd0;
            vpix_q    <= 4'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            entry_q   <= entry_d;
            cnt_q     <= cnt_d;
            target_q  <= target_d;
            vpos_q    <= vpos_d;
            vpix_q    <= vpix_d;
            overrun_q <= overrun_d;
        end
    end

    // Byte data lags the address by one cycle, so strobes sit on fetch cycles 1..4.
    assign bus.ram_addr  = {entry_q, cnt_q[1:0]};
    assign bus.lat_indx  = (state_q == S_FETCH) && (cnt_q == 3'd1);
    assign bus.lat_xdat  = (state_q == S_FETCH) && (cnt_q == 3'd2);
    assign bus.lat_vpos  = (state_q == S_FETCH) && (cnt_q == 3'd3);
    assign bus.lat_hpos  = (state_q == S_FETCH) && (cnt_q == 3'd4);
    assign bus.draw_req  = (state_q == S_DRAW);
    assign bus.draw_vpix = vpix_q;
    assign bus.busy      = scanning;
    assign bus.line_done = (state_q == S_DONE);
    assign bus.overrun   = overrun_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_sprite_list_sequencer.sv
// Bench for sprite_list_sequencer: a schedule model (one expected item per cycle,
// draw items repeat until acked) checked every cycle, plus literal scenario checks.
module tb_sprite_list_sequencer;
    localparam int N = 4;
    localparam int H = 16;

    localparam logic [1:0] K_FETCH = 2'd0;
    localparam logic [1:0] K_EVAL  = 2'd1;
    localparam logic [1:0] K_DRAW  = 2'd2;
    localparam logic [1:0] K_DONE  = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] fcyc;
        logic [8:0] entry;
        logic [3:0] vpix;
    } item_t;

    logic pixel_clk = 1'b0;
    logic rst;
    logic [7:0] mem [0:4*N-1];

    sprite_list_sequencer_if bus();

    sprite_list_sequencer #(.NUM_SPRITES(N), .SPR_HEIGHT(H)) dut (
        .pixel_clk        (pixel_clk),
        .SPR_ROM_ADDR_RST (rst),
        .bus              (bus)
    );

    always #5 pixel_clk = ~pixel_clk;

    always @(posedge pixel_clk) bus.ram_q <= mem[bus.ram_addr[3:0]];

    item_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic ovr_exp = 1'b0;
    logic prev_req = 1'b0;
    logic prev_ls = 1'b0;
    int ack_delay = 1;
    int age = 0;
    int ld_cnt = 0, ovr_cnt = 0, req_cnt = 0, strobe_cnt = 0;
    int ld_cyc = 0, ls_cyc = 0;
    logic [3:0]  last_vpix = 4'd0;
    logic [10:0] post_draw_addr = 11'h7ff;
    logic [10:0] addr_after_ls = 11'h7ff;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic build(input logic [7:0] tgt);
        logic [7:0] d;
        q.delete();
        for (int e = 0; e < N; e++) begin
            for (int c = 0; c < 5; c++) q.push_back({K_FETCH, 3'(c), 9'(e), 4'd0});
            q.push_back({K_EVAL, 3'd0, 9'(e), 4'd0});
            d = tgt - mem[4*e+2];
            if (d < 8'(H)) q.push_back({K_DRAW, 3'd0, 9'(e), d[3:0]});
        end
        q.push_back({K_DONE, 3'd0, 9'd0, 4'd0});
    endtask

    task automatic check_and_step();
        logic [7:0]  ef, af;
        logic [10:0] ea, aa;
        logic [3:0]  ev, av;
        logic        busy_now;
        item_t       it;
        cyc++;
        af = {bus.busy, bus.line_done, bus.overrun, bus.draw_req,
              bus.lat_indx, bus.lat_xdat, bus.lat_vpos, bus.lat_hpos};
        if (rst) begin
            chk("reset_outs", {af, bus.ram_addr, bus.draw_vpix, bus.dbg_state},
                {8'd0, 11'd0, 4'd0, 3'd0});
            q.delete();
            ovr_exp  = 1'b0;
            prev_req = 1'b0;
            prev_ls  = 1'b0;
            return;
        end
        ef = {2'b00, ovr_exp, 5'b0};
        ea = 11'd0; aa = 11'd0; ev = 4'd0; av = 4'd0;
        if (q.size() > 0) begin
            it = q[0];
            case (it.kind)
                K_FETCH: begin
                    ef[7] = 1'b1;
                    if (it.fcyc < 3'd4) begin
                        ea = {it.entry, it.fcyc[1:0]};
                        aa = bus.ram_addr;
                    end
                    if (it.fcyc >= 3'd1) ef[4 - int'(it.fcyc)] = 1'b1;
                end
                K_EVAL: ef[7] = 1'b1;
                K_DRAW: begin
                    ef[7] = 1'b1;
                    ef[4] = 1'b1;
                    ev = it.vpix;
                    av = bus.draw_vpix;
                end
                default: ef[6] = 1'b1;
            endcase
        end
        chk("cycle", {af, aa, av}, {ef, ea, ev});

        if (bus.line_done) begin ld_cnt++; ld_cyc = cyc; end
        if (bus.overrun) ovr_cnt++;
        strobe_cnt += int'(bus.lat_indx) + int'(bus.lat_xdat) + int'(bus.lat_vpos) + int'(bus.lat_hpos);
        if (bus.draw_req) begin req_cnt++; last_vpix = bus.draw_vpix; end
        if (prev_req && !bus.draw_req) post_draw_addr = bus.ram_addr;
        if (prev_ls) addr_after_ls = bus.ram_addr;
        if (bus.line_start) ls_cyc = cyc;

        busy_now = (q.size() > 0) && (q[0].kind != K_DONE);
        ovr_exp = 1'b0;
        if (bus.line_start) begin
            ovr_exp = busy_now;
            build(bus.target_line);
        end else if (q.size() > 0) begin
            if (q[0].kind != K_DRAW || bus.draw_ack) void'(q.pop_front());
        end
        prev_req = bus.draw_req;
        prev_ls  = bus.line_start;
    endtask

    task automatic tick();
        @(negedge pixel_clk);
        check_and_step();
        @(posedge pixel_clk);
        #1;
        if (bus.draw_req) age++; else age = 0;
        if (ack_delay == 0) bus.draw_ack = 1'($urandom_range(0, 1));
        else bus.draw_ack = bus.draw_req && (age == ack_delay);
    endtask

    task automatic start_line(input logic [7:0] tgt);
        bus.target_line = tgt;
        bus.line_start = 1'b1;
        tick();
        bus.line_start = 1'b0;
    endtask

    task automatic wait_scan(input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin tick(); n++; end
        if (q.size() > 0) begin
            total++; bad++;
            $display("FAIL scan_timeout: model queue %0d items left after %0d cycles", q.size(), n);
            q.delete();
        end
        tick();
        tick();
    endtask

    task automatic fill(input logic [7:0] vp);
        for (int i = 0; i < 4*N; i++) mem[i] = 8'($urandom_range(0, 255));
        for (int e = 0; e < N; e++) mem[4*e+2] = vp;
    endtask

    initial begin
        int r0, l0, o0, s0, ovat, n;
        logic [7:0] tgt;
        rst = 1'b1;
        bus.line_start = 1'b0;
        bus.target_line = 8'd0;
        bus.draw_ack = 1'b0;
        fill(8'h80);
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // All miss: 16 ordered strobes, line_done 25 cycles after line_start.
        ack_delay = 1;
        r0 = req_cnt; s0 = strobe_cnt;
        start_line(8'h10);
        wait_scan(200);
        chk("done_latency", 32'(ld_cyc - ls_cyc), 32'd25);
        chk("strobe_count", 32'(strobe_cnt - s0), 32'd16);
        chk("no_req_miss", 32'(req_cnt - r0), 32'd0);

        // Entry 2 hits with diff 5, ack on third request cycle.
        fill(8'h80);
        mem[10] = 8'h0A;
        ack_delay = 3;
        r0 = req_cnt;
        start_line(8'h0F);
        wait_scan(200);
        chk("req_len", 32'(req_cnt - r0), 32'd3);
        chk("vpix_5", 32'(last_vpix), 32'd5);
        chk("resume_addr", 32'(post_draw_addr), 32'd12);

        // Wrapping difference: 0x03 - 0xFA = 9 hits, 0x00 - 0xF0 = 16 misses.
        fill(8'h80);
        mem[2] = 8'hFA;
        ack_delay = 1;
        r0 = req_cnt;
        start_line(8'h03);
        wait_scan(200);
        chk("wrap_hit_req", 32'(req_cnt - r0), 32'd1);
        chk("wrap_vpix_9", 32'(last_vpix), 32'd9);
        fill(8'h80);
        mem[6] = 8'hF0;
        r0 = req_cnt;
        start_line(8'h00);
        wait_scan(200);
        chk("edge_miss_16", 32'(req_cnt - r0), 32'd0);

        // Abort during DRAW: overrun, restart at address 0, only one line_done.
        fill(8'h80);
        mem[6] = 8'h20;
        ack_delay = 1000;
        start_line(8'h20);
        n = 0;
        while (!bus.draw_req && n < 40) begin tick(); n++; end
        chk("reach_draw", 32'(bus.draw_req), 32'd1);
        tick();
        l0 = ld_cnt; o0 = ovr_cnt;
        start_line(8'h50);
        wait_scan(200);
        chk("overrun_once", 32'(ovr_cnt - o0), 32'd1);
        chk("done_once", 32'(ld_cnt - l0), 32'd1);
        chk("restart_addr", 32'(addr_after_ls), 32'd0);
        ack_delay = 1;

        // Reset held for three cycles in the middle of FETCH.
        start_line(8'h10);
        tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        l0 = ld_cnt; o0 = ovr_cnt;
        repeat (10) tick();
        chk("rst_no_done", 32'(ld_cnt - l0), 32'd0);
        chk("rst_no_ovr", 32'(ovr_cnt - o0), 32'd0);
        addr_after_ls = 11'h7ff;
        start_line(8'h10);
        wait_scan(200);
        chk("rst_start_addr", 32'(addr_after_ls), 32'd0);

        // Randomized scans with random ack timing and occasional mid-scan restarts.
        for (int it = 0; it < 30; it++) begin
            tgt = 8'($urandom_range(0, 255));
            for (int i = 0; i < 4*N; i++) mem[i] = 8'($urandom_range(0, 255));
            for (int e = 0; e < N; e++) mem[4*e+2] = tgt - 8'($urandom_range(0, 30));
            ack_delay = $urandom_range(0, 4);
            ovat = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 25) : -1;
            start_line(tgt);
            n = 0;
            while (q.size() > 0 && n < 400) begin
                if (n == ovat) start_line(8'($urandom_range(0, 255)));
                else tick();
                n++;
            end
            wait_scan(400);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
